// File: rtl/flag_event_gen.sv
// Flag event source: button sync/debounce, press/release/long-press detect,
// din change detect and an optional periodic tick (compiled in with FLAG_TIMER_EN).
module flag_btn_lane #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press_o,
  output logic release_o,
  output logic lp_rise_o,
  output logic long_press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic          sync1_q, s_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          lp_q, lp_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = ~stable_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
    // hold counts edges with stable already high, so it reaches the max
    // exactly LONG_PRESS_CYCLES edges after stable rose
    hold_d = '0;
    if (stable_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    lp_d = stable_d && (hold_d == HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      hold_q   <= '0;
      lp_q     <= 1'b0;
    end else begin
      sync1_q  <= button;
      s_q      <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      lp_q     <= lp_d;
    end
  end

  assign press_o      = ~stable_q & stable_d;
  assign release_o    = stable_q & ~stable_d;
  assign lp_rise_o    = lp_d & ~lp_q;
  assign long_press_o = lp_q;
endmodule

module flag_event_gen #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int TICK_CYCLES       = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic [7:0] din,
  output logic [7:0] flag_inputs,
  output logic [3:0] long_press
);
  localparam int NUM_BTN = 4;

  logic [NUM_BTN-1:0] press, rel, lp_rise;
  logic [7:0]         flag_q, flag_d;
  logic [7:0]         din_prev_q;
  logic               tick;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    flag_btn_lane #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .button      (buttons[i]),
      .press_o     (press[i]),
      .release_o   (rel[i]),
      .lp_rise_o   (lp_rise[i]),
      .long_press_o(long_press[i])
    );
  end

`ifdef FLAG_TIMER_EN
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    tick   = (tick_q == TICK_LAST);
    tick_d = tick ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end
`else
  logic unused_tick_cycles;
  assign unused_tick_cycles = ^TICK_CYCLES;
  assign tick = 1'b0;
`endif

  always_comb begin
    flag_d      = '0;
    flag_d[3:0] = press;
    flag_d[4]   = tick;
    flag_d[5]   = |rel;
    flag_d[6]   = |lp_rise;
    flag_d[7]   = (din != din_prev_q);
  end

  // din_prev tracks din even in reset so no change pulse follows reset
  always_ff @(posedge clk) begin
    din_prev_q <= din;
    if (reset) flag_q <= '0;
    else       flag_q <= flag_d;
  end

  assign flag_inputs = flag_q;
endmodule

// File: tb/tb_flag_event_gen.sv
// Directed bench for flag_event_gen (DEBOUNCE=4, LONG_PRESS=20, TICK=10);
// bit 4 is masked except in the tick scenario.
module tb_flag_event_gen;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic [7:0] din;
  logic [7:0] flag_inputs;
  logic [3:0] long_press;
  int n_chk = 0;
  int n_err = 0;

  flag_event_gen #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .TICK_CYCLES      (10)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .din        (din),
    .flag_inputs(flag_inputs),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fl();
    return flag_inputs & 8'hEF;
  endfunction

  // k counts edges from the first edge that samples the new input (edge 0)
  task automatic run_expect(input string tag, input int n, input int at, input logic [7:0] val);
    for (int k = 0; k < n; k++) begin
      step();
      chk($sformatf("%s[%0d]", tag, k), fl(), (k == at) ? val : 8'h00);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; buttons = 4'h0; din = 8'h3C;
    repeat (3) step();
    chk("rst_flags", flag_inputs, 8'h00);
    chk("rst_lp", {4'h0, long_press}, 8'h00);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst[%0d]", k), fl(), 8'h00);
    end

    din = 8'hA5; run_expect("din_a5", 6, 0, 8'h80);
    din = 8'h5A; run_expect("din_5a", 6, 0, 8'h80);

    buttons = 4'b0001; run_expect("press0", 7, 5, 8'h01);
    buttons = 4'b0000; run_expect("rel0",   7, 5, 8'h20);

    buttons = 4'b0011; run_expect("press01", 7, 5, 8'h03);
    buttons = 4'b1100; run_expect("swap",    7, 5, 8'h2C);
    buttons = 4'b0000; run_expect("rel23",   7, 5, 8'h20);

    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      buttons = {1'b0, ((j / 2) % 2 == 0), 2'b00};
      step();
      if (fl() != 8'h00) cnt++;
    end
    chk("bounce_quiet", 8'(cnt), 8'h00);
    buttons = 4'b0100; run_expect("bounce", 7, 5, 8'h04);
    buttons = 4'b0000; run_expect("rel2",   7, 5, 8'h20);

    // hold button 1 for edges 0..39; stable rises at 5, falls at 45
    buttons = 4'b0010;
    for (int k = 0; k < 51; k++) begin
      if (k == 40) buttons = 4'b0000;
      step();
      chk($sformatf("lp_flag[%0d]", k), fl(),
          (k == 5) ? 8'h02 : (k == 25) ? 8'h40 : (k == 45) ? 8'h20 : 8'h00);
      chk($sformatf("lp_lvl[%0d]", k), {4'h0, long_press},
          (k >= 25 && k < 45) ? 8'h02 : 8'h00);
    end

    reset = 1'b1; step(); reset = 1'b0;
`ifdef FLAG_TIMER_EN
    for (int c = 1; c <= 35; c++) begin
      step();
      chk($sformatf("tick[%0d]", c), {7'h0, flag_inputs[4]}, (c % 10 == 0) ? 8'h01 : 8'h00);
    end
`else
    cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (flag_inputs[4]) cnt++;
    end
    chk("no_tick", 8'(cnt), 8'h00);
`endif

    buttons = 4'b1000; run_expect("press3", 15, 5, 8'h08);
    reset = 1'b1;
    step();
    chk("midhold_rst_flags", flag_inputs, 8'h00);
    chk("midhold_rst_lp", {4'h0, long_press}, 8'h00);
    step();
    chk("midhold_rst_flags2", flag_inputs, 8'h00);
    reset = 1'b0;
    // first edge after reset re-samples the held button (acts as edge 0)
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("rehold_flag[%0d]", k), fl(),
          (k == 6) ? 8'h08 : (k == 26) ? 8'h40 : 8'h00);
      chk($sformatf("rehold_lp[%0d]", k), {4'h0, long_press}, (k >= 26) ? 8'h08 : 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
